// File: rtl/dma_copy_engine_if.sv
// rtl/dma_copy_engine_if.sv - host/RAM signal bundle for dma_copy_engine (fill ports with DMA_FILL_MODE_EN)
interface dma_copy_engine_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10
);
  // Transfer request
  logic                  start;
  logic [ADDR_WIDTH-1:0] sourceAddress;
  logic [ADDR_WIDTH-1:0] destAddress;
  logic [LEN_WIDTH-1:0]  length;
`ifdef DMA_FILL_MODE_EN
  logic [DATA_WIDTH-1:0] fillValue;
  logic                  fillMode;
`endif
  // CPU pass-through side
  logic [ADDR_WIDTH-1:0] cpuAddress;
  logic [DATA_WIDTH-1:0] cpuDataC;
  logic                  cpuWriteEnable;
  // Status
  logic                  busy;
  logic                  done;
  // Data RAM side
  logic [ADDR_WIDTH-1:0] ramAddress;
  logic [DATA_WIDTH-1:0] ramDataC;
  logic                  ramWriteEnable;
  logic [DATA_WIDTH-1:0] ramDataOutput;

  modport slave (
`ifdef DMA_FILL_MODE_EN
    input  fillValue, fillMode,
`endif
    input  start, sourceAddress, destAddress, length,
    input  cpuAddress, cpuDataC, cpuWriteEnable,
    output busy, done,
    output ramAddress, ramDataC, ramWriteEnable,
    input  ramDataOutput
  );

  modport master (
`ifdef DMA_FILL_MODE_EN
    output fillValue, fillMode,
`endif
    output start, sourceAddress, destAddress, length,
    output cpuAddress, cpuDataC, cpuWriteEnable,
    input  busy, done,
    input  ramAddress, ramDataC, ramWriteEnable,
    output ramDataOutput
  );
endinterface

// File: rtl/dma_copy_engine.sv
// rtl/dma_copy_engine.sv - word-copy DMA engine owning the data RAM port; fill mode with DMA_FILL_MODE_EN
module dma_copy_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 10
) (
  input  logic               clock,
  input  logic               resetN,
  dma_copy_engine_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] src_q, src_d;
  logic [ADDR_WIDTH-1:0] dst_q, dst_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
`ifdef DMA_FILL_MODE_EN
  logic                  fill_q, fill_d;
  logic [DATA_WIDTH-1:0] fill_value_q, fill_value_d;
`endif

  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_we;
  logic                  busy_c;
  logic                  done_c;

  // State and transfer-context registers; reset abandons any transfer in flight
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      remaining_q  <= '0;
`ifdef DMA_FILL_MODE_EN
      fill_q       <= 1'b0;
      fill_value_q <= '0;
`endif
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      remaining_q  <= remaining_d;
`ifdef DMA_FILL_MODE_EN
      fill_q       <= fill_d;
      fill_value_q <= fill_value_d;
`endif
    end
  end

  // Next-state logic and RAM port mux: CPU owns the port except in READ/WRITE
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    dst_d        = dst_q;
    remaining_d  = remaining_q;
`ifdef DMA_FILL_MODE_EN
    fill_d       = fill_q;
    fill_value_d = fill_value_q;
`endif
    ram_address  = bus.cpuAddress;
    ram_data     = bus.cpuDataC;
    ram_we       = bus.cpuWriteEnable;
    busy_c       = 1'b0;
    done_c       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.length == '0) begin
            state_d = S_DONE;
          end else begin
            src_d       = bus.sourceAddress;
            dst_d       = bus.destAddress;
            remaining_d = bus.length;
`ifdef DMA_FILL_MODE_EN
            fill_d       = bus.fillMode;
            fill_value_d = bus.fillValue;
            state_d      = bus.fillMode ? S_WRITE : S_READ;
`else
            state_d      = S_READ;
`endif
          end
        end
      end

      S_READ: begin
        // Register the source address; its word appears on ramDataOutput next cycle
        ram_address = src_q;
        ram_data    = '0;
        ram_we      = 1'b0;
        busy_c      = 1'b1;
        state_d     = S_WRITE;
      end

      S_WRITE: begin
        ram_address = dst_q;
`ifdef DMA_FILL_MODE_EN
        ram_data    = fill_q ? fill_value_q : bus.ramDataOutput;
`else
        ram_data    = bus.ramDataOutput;
`endif
        ram_we      = 1'b1;
        busy_c      = 1'b1;
        src_d       = src_q + ADDR_WIDTH'(1);
        dst_d       = dst_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - LEN_WIDTH'(1);
        if (remaining_q == LEN_WIDTH'(1)) begin
          state_d = S_DONE;
        end else begin
`ifdef DMA_FILL_MODE_EN
          state_d = fill_q ? S_WRITE : S_READ;
`else
          state_d = S_READ;
`endif
        end
      end

      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy           = busy_c;
  assign bus.done           = done_c;
  assign bus.ramAddress     = ram_address;
  assign bus.ramDataC       = ram_data;
  // Write strobe is held off for the whole reset window, even in pass-through
  assign bus.ramWriteEnable = ram_we & resetN;

endmodule

// File: tb/tb_dma_copy_engine.sv
// tb/tb_dma_copy_engine.sv - scoreboard bench for dma_copy_engine
module tb_dma_copy_engine;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int LW = 10;

  logic clock;
  logic resetN;
  int   n_checks;
  int   n_fail;

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  wr_t           sb[$];
  logic [DW-1:0] model[1024];
  logic [DW-1:0] mem[1024];
  logic [AW-1:0] addr_reg;

  dma_copy_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus();

  dma_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered-address RAM with new-data read behaviour
  always @(posedge clock) begin
    if (bus.ramWriteEnable) mem[bus.ramAddress] <= bus.ramDataC;
    addr_reg <= bus.ramAddress;
  end
  assign bus.ramDataOutput = mem[addr_reg];

  // Engine writes are popped from the scoreboard and compared in order
  always @(negedge clock) begin
    if (resetN && bus.busy && bus.ramWriteEnable) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_write: addr=%0d data=%h, required no write", bus.ramAddress, bus.ramDataC);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (bus.ramAddress !== e.a || bus.ramDataC !== e.d) begin
          n_fail++;
          $display("FAIL sb_write: addr=%0d data=%h, required addr=%0d data=%h", bus.ramAddress, bus.ramDataC, e.a, e.d);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.cpuAddress     = a;
    bus.cpuDataC       = d;
    bus.cpuWriteEnable = 1'b1;
    @(posedge clock); #1;
    bus.cpuWriteEnable = 1'b0;
    model[a] = d;
  endtask

  task automatic expect_copy(input logic [AW-1:0] s, input logic [AW-1:0] t, input int n);
    logic [AW-1:0] sa, da;
    wr_t e;
    sa = s; da = t;
    for (int i = 0; i < n; i++) begin
      e.a = da;
      e.d = model[sa];
      model[da] = model[sa];
      sb.push_back(e);
      sa = sa + 10'd1;
      da = da + 10'd1;
    end
  endtask

  task automatic kick(input logic [AW-1:0] s, input logic [AW-1:0] t, input logic [LW-1:0] n);
    bus.sourceAddress = s;
    bus.destAddress   = t;
    bus.length        = n;
    bus.start         = 1'b1;
    @(posedge clock); #1;
    bus.start         = 1'b0;
  endtask

  task automatic test_reset;
    bus.cpuWriteEnable = 1'b1;
    bus.cpuAddress     = 10'd3;
    @(negedge clock);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.ramWriteEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b we=%b, required 0 0 0", bus.busy, bus.done, bus.ramWriteEnable);
    end
    bus.cpuWriteEnable = 1'b0;
    @(posedge clock); #1;
    resetN = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_passthrough;
    bus.cpuAddress     = 10'd5;
    bus.cpuDataC       = 32'h0000A5A5;
    bus.cpuWriteEnable = 1'b1;
    @(negedge clock);
    n_checks++;
    if (bus.ramAddress !== 10'd5 || bus.ramDataC !== 32'h0000A5A5 || bus.ramWriteEnable !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL pass_mirror: addr=%0d data=%h we=%b busy=%b, required 5 0000a5a5 1 0",
               bus.ramAddress, bus.ramDataC, bus.ramWriteEnable, bus.busy);
    end
    @(posedge clock); #1;
    bus.cpuWriteEnable = 1'b0;
    model[5] = 32'h0000A5A5;
    n_checks++;
    if (bus.ramDataOutput !== 32'h0000A5A5) begin
      n_fail++;
      $display("FAIL pass_read: got %h, required 0000a5a5", bus.ramDataOutput);
    end
  endtask

  task automatic test_copy;
    int cyc, busy_cnt;
    bit got;
    for (int i = 0; i < 4; i++) cpu_write(10'(10 + i), 32'(i + 1));
    expect_copy(10'd10, 10'd20, 4);
    bus.cpuAddress = 10'd999;
    kick(10'd10, 10'd20, 10'd4);
    cyc = 0; busy_cnt = 0; got = 0;
    while (!got && cyc < 50) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        n_checks++;
        if (bus.ramAddress !== 10'd10 || bus.ramWriteEnable !== 1'b0) begin
          n_fail++;
          $display("FAIL copy_first_read: addr=%0d we=%b, required 10 0", bus.ramAddress, bus.ramWriteEnable);
        end
      end
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1;
    end
    n_checks++;
    if (!got || cyc != 9) begin
      n_fail++;
      $display("FAIL copy_done_cycle: got=%0d cycle=%0d, required 9", got, cyc);
    end
    n_checks++;
    if (busy_cnt != 8) begin
      n_fail++;
      $display("FAIL copy_busy_cycles: %0d, required 8", busy_cnt);
    end
    @(posedge clock); #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (mem[20 + i] !== 32'(i + 1)) begin
        n_fail++;
        $display("FAIL copy_data[%0d]: %h, required %h", 20 + i, mem[20 + i], 32'(i + 1));
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL copy_sb_left: %0d entries, required 0", sb.size());
    end
  endtask

  task automatic test_zero_length;
    bus.cpuWriteEnable = 1'b0;
    kick(10'd50, 10'd60, 10'd0);
    @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.ramWriteEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_c1: done=%b busy=%b we=%b, required 1 0 0", bus.done, bus.busy, bus.ramWriteEnable);
    end
    @(negedge clock);
    n_checks++;
    if (bus.done !== 1'b0 || bus.ramWriteEnable !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_c2: done=%b we=%b, required 0 0", bus.done, bus.ramWriteEnable);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_wrap_overlap;
    int cyc;
    bit got;
    cpu_write(10'd1022, 32'h111);
    cpu_write(10'd1023, 32'h222);
    cpu_write(10'd0,    32'h333);
    expect_copy(10'd1022, 10'd0, 3);
    kick(10'd1022, 10'd0, 10'd3);
    cyc = 0; got = 0;
    while (!got && cyc < 50) begin
      @(negedge clock); cyc++;
      if (bus.done) got = 1;
    end
    n_checks++;
    if (!got || cyc != 7) begin
      n_fail++;
      $display("FAIL wrap_done_cycle: got=%0d cycle=%0d, required 7", got, cyc);
    end
    @(posedge clock); #1;
    // Word 0 is rewritten by the first write, before the third read fetches it
    n_checks++;
    if (mem[0] !== 32'h111 || mem[1] !== 32'h222 || mem[2] !== 32'h111) begin
      n_fail++;
      $display("FAIL wrap_data: %h %h %h, required 111 222 111", mem[0], mem[1], mem[2]);
    end
    cpu_write(10'd4, 32'd7);
    cpu_write(10'd5, 32'h55);
    cpu_write(10'd6, 32'h66);
    cpu_write(10'd7, 32'h77);
    expect_copy(10'd4, 10'd5, 3);
    kick(10'd4, 10'd5, 10'd3);
    cyc = 0; got = 0;
    while (!got && cyc < 50) begin
      @(negedge clock); cyc++;
      if (bus.done) got = 1;
    end
    @(posedge clock); #1;
    n_checks++;
    if (!got || mem[5] !== 32'd7 || mem[6] !== 32'd7 || mem[7] !== 32'd7) begin
      n_fail++;
      $display("FAIL overlap_data: got=%0d %h %h %h, required 7 7 7", got, mem[5], mem[6], mem[7]);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL overlap_sb_left: %0d entries, required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid;
    int cyc;
    bit got;
    for (int i = 0; i < 8; i++) begin
      cpu_write(10'(200 + i), 32'h1000 + 32'(i));
      cpu_write(10'(300 + i), 32'hBAD0 + 32'(i));
    end
    expect_copy(10'd200, 10'd300, 2);
    kick(10'd200, 10'd300, 10'd8);
    repeat (5) @(posedge clock);
    #2;
    n_checks++;
    if (bus.busy !== 1'b1 || bus.ramWriteEnable !== 1'b1 || bus.ramAddress !== 10'd302) begin
      n_fail++;
      $display("FAIL rst_mid_pre: busy=%b we=%b addr=%0d, required 1 1 302", bus.busy, bus.ramWriteEnable, bus.ramAddress);
    end
    bus.cpuWriteEnable = 1'b1;
    bus.cpuAddress     = 10'd303;
    resetN = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.ramWriteEnable !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_drop: busy=%b we=%b done=%b, required 0 0 0", bus.busy, bus.ramWriteEnable, bus.done);
    end
    @(posedge clock); #1;
    bus.cpuWriteEnable = 1'b0;
    resetN = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (mem[300 + i] !== model[300 + i]) begin
        n_fail++;
        $display("FAIL rst_mid_dst[%0d]: %h, required %h", 300 + i, mem[300 + i], model[300 + i]);
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL rst_mid_sb_left: %0d entries, required 0", sb.size());
    end
    expect_copy(10'd200, 10'd400, 2);
    kick(10'd200, 10'd400, 10'd2);
    cyc = 0; got = 0;
    while (!got && cyc < 50) begin
      @(negedge clock); cyc++;
      if (bus.done) got = 1;
    end
    @(posedge clock); #1;
    n_checks++;
    if (!got || cyc != 5 || mem[400] !== 32'h1000 || mem[401] !== 32'h1001) begin
      n_fail++;
      $display("FAIL rst_restart: got=%0d cycle=%0d %h %h, required cycle 5 1000 1001", got, cyc, mem[400], mem[401]);
    end
  endtask

`ifdef DMA_FILL_MODE_EN
  task automatic test_fill;
    int cyc, busy_cnt;
    bit got;
    wr_t e;
    for (int i = 0; i < 5; i++) begin
      e.a = 10'(100 + i);
      e.d = 32'hDEADBEEF;
      sb.push_back(e);
    end
    bus.fillMode  = 1'b1;
    bus.fillValue = 32'hDEADBEEF;
    kick(10'd7, 10'd100, 10'd5);
    cyc = 0; busy_cnt = 0; got = 0;
    while (!got && cyc < 50) begin
      @(negedge clock); cyc++;
      if (bus.busy) busy_cnt++;
      if (bus.done) got = 1;
    end
    bus.fillMode = 1'b0;
    n_checks++;
    if (!got || cyc != 6 || busy_cnt != 5) begin
      n_fail++;
      $display("FAIL fill_timing: got=%0d cycle=%0d busy=%0d, required 6 5", got, cyc, busy_cnt);
    end
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (mem[100 + i] !== 32'hDEADBEEF) begin
        n_fail++;
        $display("FAIL fill_data[%0d]: %h, required deadbeef", 100 + i, mem[100 + i]);
      end
    end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetN   = 1'b0;
    bus.start          = 1'b0;
    bus.sourceAddress  = '0;
    bus.destAddress    = '0;
    bus.length         = '0;
    bus.cpuAddress     = '0;
    bus.cpuDataC       = '0;
    bus.cpuWriteEnable = 1'b0;
`ifdef DMA_FILL_MODE_EN
    bus.fillMode       = 1'b0;
    bus.fillValue      = '0;
`endif
    for (int i = 0; i < 1024; i++) model[i] = '0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_passthrough();
    test_copy();
    test_zero_length();
    test_wrap_overlap();
    test_reset_mid();
`ifdef DMA_FILL_MODE_EN
    test_fill();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
